// File: rtl/tc_pkg.sv
// Shared encodings for the tc_multi timer block: FSM states, register offsets,
// CTRL field positions and MODE values.
package tc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_CNT  = 2'b10,
    ST_INT  = 2'b11
  } tc_state_e;

  localparam logic [1:0] REG_CTRL   = 2'd0;
  localparam logic [1:0] REG_PRESET = 2'd1;
  localparam logic [1:0] REG_COUNT  = 2'd2;
  localparam logic [1:0] REG_STATUS = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_MODE_LO = 1;
  localparam int CTRL_MODE_HI = 2;
  localparam int CTRL_IM      = 3;
  localparam int CTRL_PS_LO   = 8;
  localparam int CTRL_PS_HI   = 15;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

  // Any non-one-shot encoding reloads.
  function automatic logic mode_reloads(input logic [1:0] mode);
    return (mode == MODE_RELOAD) || mode[1];
  endfunction

endpackage

// File: rtl/tc_channel.sv
// One tc_multi timer channel: CTRL/PRESET/COUNT/STATUS registers and the
// IDLE/LOAD/CNT/INT FSM. Per-channel prescaler exists when TC_PRESCALE_EN is defined.
module tc_channel
  import tc_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        we_i,
  input  logic [1:0]  sel_i,
  input  logic [31:0] din_i,
  output logic [31:0] rdata_o,
  output logic        irq_o
);

  localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

  tc_state_e        state_q;
  logic             en_q;
  logic             im_q;
  logic             pend_q;
  logic [1:0]       mode_q;
  logic [WIDTH-1:0] preset_q;
  logic [WIDTH-1:0] count_q;
  logic             tick_s;
  logic [31:0]      ctrl_rd_s;
  logic             unused_din_s;

`ifdef TC_PRESCALE_EN
  logic [7:0] presc_q;
  logic [7:0] pcnt_q;
  assign tick_s = (pcnt_q == presc_q);
`else
  assign tick_s = 1'b1;
`endif

  assign unused_din_s = ^din_i;
  assign irq_o        = pend_q & im_q;

  // Register writes stall this channel's FSM for the cycle; otherwise the FSM advances.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      en_q     <= 1'b0;
      im_q     <= 1'b0;
      pend_q   <= 1'b0;
      mode_q   <= 2'b00;
      preset_q <= {WIDTH{1'b0}};
      count_q  <= {WIDTH{1'b0}};
`ifdef TC_PRESCALE_EN
      presc_q  <= 8'd0;
      pcnt_q   <= 8'd0;
`endif
    end else if (we_i) begin
`ifdef TC_PRESCALE_EN
      pcnt_q <= 8'd0;
`endif
      case (sel_i)
        REG_CTRL: begin
          en_q   <= din_i[CTRL_EN];
          mode_q <= din_i[CTRL_MODE_HI:CTRL_MODE_LO];
          im_q   <= din_i[CTRL_IM];
`ifdef TC_PRESCALE_EN
          presc_q <= din_i[CTRL_PS_HI:CTRL_PS_LO];
`endif
        end
        REG_PRESET: preset_q <= din_i[WIDTH-1:0];
        REG_COUNT:  count_q  <= din_i[WIDTH-1:0];
        REG_STATUS: pend_q   <= pend_q & ~din_i[0];
        default:    pend_q   <= pend_q;
      endcase
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (en_q) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          count_q <= preset_q;
          state_q <= ST_CNT;
`ifdef TC_PRESCALE_EN
          pcnt_q  <= 8'd0;
`endif
        end
        ST_CNT: begin
          if (!en_q) begin
            state_q <= ST_IDLE;
          end else if (tick_s) begin
`ifdef TC_PRESCALE_EN
            pcnt_q <= 8'd0;
`endif
            if (count_q > CNT_ONE) begin
              count_q <= count_q - CNT_ONE;
            end else begin
              count_q <= {WIDTH{1'b0}};
              pend_q  <= 1'b1;
              state_q <= ST_INT;
            end
          end
`ifdef TC_PRESCALE_EN
          else begin
            pcnt_q <= pcnt_q + 8'd1;
          end
`endif
        end
        ST_INT: begin
          if (mode_reloads(mode_q)) begin
            state_q <= ST_LOAD;
          end else begin
            en_q    <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Read word for the selected register; unstored CTRL bits read as zero.
  always_comb begin
    ctrl_rd_s                            = 32'd0;
    ctrl_rd_s[CTRL_EN]                   = en_q;
    ctrl_rd_s[CTRL_MODE_HI:CTRL_MODE_LO] = mode_q;
    ctrl_rd_s[CTRL_IM]                   = im_q;
`ifdef TC_PRESCALE_EN
    ctrl_rd_s[CTRL_PS_HI:CTRL_PS_LO]     = presc_q;
`else
    ctrl_rd_s[CTRL_PS_HI:CTRL_PS_LO]     = 8'd0;
`endif
    rdata_o = 32'd0;
    case (sel_i)
      REG_CTRL:   rdata_o = ctrl_rd_s;
      REG_PRESET: rdata_o = 32'(preset_q);
      REG_COUNT:  rdata_o = 32'(count_q);
      REG_STATUS: rdata_o = {29'd0, state_q, pend_q};
      default:    rdata_o = 32'd0;
    endcase
  end

endmodule

// File: rtl/tc_multi.sv
// NUM_CH-channel bus timer behind one word-addressed slave port, with combined IRQ.
// Optional per-channel prescaler enabled by defining TC_PRESCALE_EN.
module tc_multi
  import tc_pkg::*;
#(
  parameter int NUM_CH = 2,
  parameter int WIDTH  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:2] Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  output logic        IRQ
);

  logic [3:0]        ch_sel_s;
  logic [1:0]        reg_sel_s;
  logic [31:0]       rdata_s [NUM_CH];
  logic [NUM_CH-1:0] irq_s;
  logic              unused_addr_s;

  assign ch_sel_s      = Addr[7:4];
  assign reg_sel_s     = Addr[3:2];
  assign unused_addr_s = ^Addr[31:8];

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    tc_channel #(.WIDTH(WIDTH)) u_ch (
      .clk_i   (clk),
      .rst_ni  (reset),
      .we_i    (WE && (ch_sel_s == 4'(i))),
      .sel_i   (reg_sel_s),
      .din_i   (Din),
      .rdata_o (rdata_s[i]),
      .irq_o   (irq_s[i])
    );
  end

  // One-hot OR mux; channel indices at or beyond NUM_CH match nothing and read zero.
  always_comb begin
    Dout = 32'd0;
    for (int i = 0; i < NUM_CH; i++) begin
      Dout = Dout | ((ch_sel_s == 4'(i)) ? rdata_s[i] : 32'd0);
    end
  end

  assign IRQ = |irq_s;

endmodule

// File: tb/tb_tc_multi.sv
// Directed self-checking bench for tc_multi (32-bit and 8-bit instances).
module tb_tc_multi;

  localparam logic [1:0] R_CTRL   = 2'd0;
  localparam logic [1:0] R_PRESET = 2'd1;
  localparam logic [1:0] R_COUNT  = 2'd2;
  localparam logic [1:0] R_STATUS = 2'd3;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;
  logic [31:2] addr8;
  logic        we8;
  logic [31:0] din8;
  logic [31:0] dout8;
  logic        irq8;
  int          n_cmp = 0;
  int          n_err = 0;

  tc_multi #(.NUM_CH(2), .WIDTH(32)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );

  tc_multi #(.NUM_CH(2), .WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .Addr(addr8), .WE(we8), .Din(din8), .Dout(dout8), .IRQ(irq8)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_reg(input string tag, input int ch, input logic [1:0] r, input logic [31:0] exp);
    Addr = {24'd0, 4'(ch), r};
    #1;
    check_val(tag, Dout, exp);
  endtask

  task automatic expect_irq(input string tag, input logic exp);
    check_val(tag, {31'd0, IRQ}, {31'd0, exp});
  endtask

  task automatic wr(input int ch, input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    Addr = {24'd0, 4'(ch), r};
    Din  = d;
    WE   = 1'b1;
    @(posedge clk);
    #1;
    WE = 1'b0;
  endtask

  // One-shot run on ch0: PEND expected n edges after the LOAD edge.
  task automatic run_oneshot(input string tag, input logic [31:0] p, input int n);
    wr(0, R_PRESET, p);
    wr(0, R_CTRL, 32'h9);
    step(2);
    expect_reg({tag, "_load_count"}, 0, R_COUNT, p);
    expect_reg({tag, "_cnt_state"}, 0, R_STATUS, 32'h4);
    step(n - 1);
    expect_reg({tag, "_pre_pend"}, 0, R_STATUS, 32'h4);
    expect_irq({tag, "_pre_irq"}, 1'b0);
    step(1);
    expect_reg({tag, "_pend_int"}, 0, R_STATUS, 32'h7);
    expect_irq({tag, "_irq"}, 1'b1);
    expect_reg({tag, "_count0"}, 0, R_COUNT, 32'h0);
    step(1);
    expect_reg({tag, "_idle"}, 0, R_STATUS, 32'h1);
    expect_reg({tag, "_en_clr"}, 0, R_CTRL, 32'h8);
    wr(0, R_STATUS, 32'h1);
    expect_reg({tag, "_w1c"}, 0, R_STATUS, 32'h0);
    expect_irq({tag, "_irq_drop"}, 1'b0);
    step(1);
  endtask

  initial begin
    reset = 1'b0;
    WE    = 1'b0;
    Din   = 32'd0;
    Addr  = 30'd0;
    we8   = 1'b0;
    din8  = 32'd0;
    addr8 = 30'd0;
    #12;
    expect_reg("rst_ctrl", 0, R_CTRL, 32'h0);
    expect_reg("rst_status", 1, R_STATUS, 32'h0);
    expect_irq("rst_irq", 1'b0);
    @(negedge clk);
    reset = 1'b1;

    run_oneshot("os5", 32'd5, 5);

    // Auto-reload on ch1, then W1C colliding with the next PEND set.
    wr(1, R_PRESET, 32'd3);
    wr(1, R_CTRL, 32'hB);
    step(2);
    expect_reg("ar_c3", 1, R_COUNT, 32'd3);
    step(1);
    expect_reg("ar_c2", 1, R_COUNT, 32'd2);
    step(1);
    expect_reg("ar_c1", 1, R_COUNT, 32'd1);
    step(1);
    expect_reg("ar_c0", 1, R_COUNT, 32'd0);
    expect_reg("ar_pend", 1, R_STATUS, 32'h7);
    expect_irq("ar_irq", 1'b1);
    step(5);
    expect_reg("ar_pend2", 1, R_STATUS, 32'h7);
    wr(1, R_STATUS, 32'h1);
    expect_reg("ar_w1c", 1, R_STATUS, 32'h6);
    expect_irq("ar_irq_drop", 1'b0);
    step(4);
    expect_reg("col_c1", 1, R_COUNT, 32'd1);
    expect_reg("col_pre", 1, R_STATUS, 32'h4);
    wr(1, R_STATUS, 32'h1);
    expect_reg("col_clear", 1, R_STATUS, 32'h4);
    expect_reg("col_stall", 1, R_COUNT, 32'd1);
    step(1);
    expect_reg("col_set", 1, R_STATUS, 32'h7);
    wr(1, R_CTRL, 32'h0);
    wr(1, R_STATUS, 32'h1);
    step(2);
    expect_reg("ar_stop", 1, R_STATUS, 32'h0);

    // Masked ch0 keeps counting across a write to ch1.
    wr(0, R_PRESET, 32'd6);
    wr(0, R_CTRL, 32'h1);
    step(2);
    expect_reg("iso_c6", 0, R_COUNT, 32'd6);
    wr(1, R_PRESET, 32'd7);
    expect_reg("iso_c5", 0, R_COUNT, 32'd5);
    expect_reg("iso_ch1", 1, R_PRESET, 32'd7);
    step(5);
    expect_reg("msk_pend", 0, R_STATUS, 32'h7);
    expect_irq("msk_irq0", 1'b0);
    wr(0, R_CTRL, 32'h8);
    expect_irq("msk_irq1", 1'b1);
    wr(0, R_STATUS, 32'h1);
    expect_irq("msk_clr", 1'b0);
    step(2);

    run_oneshot("p0", 32'd0, 1);
    run_oneshot("p1", 32'd1, 1);

    @(negedge clk);
    addr8 = {24'd0, 4'd0, R_PRESET};
    din8  = 32'h1FF;
    we8   = 1'b1;
    @(posedge clk);
    #1;
    we8 = 1'b0;
    #1;
    check_val("w8_trunc", dout8, 32'hFF);

    wr(2, R_PRESET, 32'h55);
    expect_reg("oob_preset", 2, R_PRESET, 32'h0);
    expect_reg("oob_ctrl", 2, R_CTRL, 32'h0);
    expect_reg("oob_keep", 0, R_PRESET, 32'd1);

`ifdef TC_PRESCALE_EN
    wr(0, R_PRESET, 32'd4);
    wr(0, R_CTRL, 32'h209);
    step(13);
    expect_reg("ps_c1", 0, R_COUNT, 32'd1);
    expect_reg("ps_pre", 0, R_STATUS, 32'h4);
    step(1);
    expect_reg("ps_pend", 0, R_STATUS, 32'h7);
    step(1);
    wr(0, R_STATUS, 32'h1);
    step(2);
`endif

    wr(1, R_CTRL, 32'h209);
`ifdef TC_PRESCALE_EN
    expect_reg("ctrl_rb", 1, R_CTRL, 32'h209);
`else
    expect_reg("ctrl_rb", 1, R_CTRL, 32'h9);
`endif
    wr(1, R_CTRL, 32'h9);
    wr(0, R_PRESET, 32'd100);
    wr(0, R_CTRL, 32'h9);
    step(10);
    expect_irq("ar_pre_irq", 1'b1);
    expect_reg("ar_pre_cnt", 0, R_COUNT, 32'd92);
    #2;
    reset = 1'b0;
    #1;
    expect_irq("arst_irq", 1'b0);
    expect_reg("arst_count", 0, R_COUNT, 32'd0);
    expect_reg("arst_st1", 1, R_STATUS, 32'h0);
    expect_reg("arst_ctrl", 0, R_CTRL, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    step(3);
    expect_reg("post_st", 0, R_STATUS, 32'h0);
    expect_reg("post_cnt", 0, R_COUNT, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tc_multi.md
Name: tc_multi

Overview:
- Parametrised successor to the single-channel bus timer: NUM_CH independent down-counters of WIDTH bits behind one word-addressed bridge slave port.
- Adds auto-reload, sticky write-1-to-clear interrupt pending, per-channel masking, and a combined IRQ line to the CP0 interrupt input.
- A bus write stalls only the addressed channel; all other channels keep counting.

Parameters:
- NUM_CH, 2, number of timer channels (1..16)
- WIDTH, 32, preset/count width in bits (2..32); zero-extended on Dout

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset (clears all state when 0)
- Addr  input  30  word address [31:2] from bridge
- WE  input  1  write enable, valid this cycle
- Din  input  32  write data
- Dout  output  32  read data, combinational from Addr
- IRQ  output  1  OR over channels of (pending & CTRL.IM)

Behaviour:
- Address decode:
  - Addr[3:2] selects the register: 0 CTRL, 1 PRESET, 2 COUNT, 3 STATUS.
  - Addr[7:4] selects the channel.
  - Channel >= NUM_CH: reads return 0, writes are ignored.
- CTRL fields:
  - [0] EN: enable.
  - [2:1] MODE: 00 one-shot, 01 auto-reload; 10 and 11 behave as 01.
  - [3] IM: interrupt mask (1 = enabled).
  - Other bits are not stored and read 0.
- STATUS fields:
  - [0] PEND.
  - [2:1] FSM state (IDLE 00, LOAD 01, CNT 10, INT 11), read-only.
  - Writing 1 to bit0 clears PEND; writing 0 has no effect.
- PRESET and COUNT: store Din[WIDTH-1:0]. COUNT is writable, for debug.
- Reset (async, reset=0): all registers 0, every FSM IDLE, PEND=0, IRQ=0.
- Write cycle, addressed channel:
  - The register update takes effect at the edge.
  - That channel's FSM holds for the cycle.
- Write cycle, other channels: they advance normally.
- Per-channel FSM, one transition per clk when not stalled:
  - IDLE: if EN, go to LOAD.
  - LOAD: COUNT <= PRESET; go to CNT.
  - CNT, EN=0: go to IDLE; COUNT holds.
  - CNT, EN=1 and COUNT>1: COUNT <= COUNT-1.
  - CNT, EN=1 and COUNT<=1: COUNT <= 0; PEND <= 1; go to INT.
  - INT, MODE=00: EN <= 0; go to IDLE.
  - INT, MODE!=00: go to LOAD (reload and continue).
- Timing:
  - With PRESET=N, PEND rises max(N,1) edges after the LOAD edge.
  - Auto-reload period is max(N,1)+2 cycles.
- PEND is sticky. Setting it again while already set is a no-op (no overflow count).
- Simultaneous PEND set by the FSM and W1C write to STATUS in the same cycle: the write stalls that channel's FSM, so the clear wins and the set occurs next cycle.
- IRQ is combinational from registered PEND and IM, so it follows IM changes in the same cycle.
- reset deasserting mid-count restarts every channel in IDLE; no state is retained.

Optional Feature:
- Macro: TC_PRESCALE_EN
- Defined:
  - CTRL[15:8] is an 8-bit prescale value P, stored.
  - In CNT, COUNT decrements (or the INT check fires) only once every P+1 cycles.
  - The prescale counter is per-channel and resets to 0 on LOAD, on any stall, and on async reset.
- Undefined: CTRL[15:8] is not stored, reads 0, and counting is every cycle.

Decomposition:
- Shared package tc_pkg:
  - State encodings IDLE/LOAD/CNT/INT.
  - Register offsets CTRL/PRESET/COUNT/STATUS.
  - CTRL bit positions EN/MODE/IM/PRESCALE.
  - MODE encodings.
- Sub-module tc_channel holds one channel's registers and FSM:
  - Inputs: write strobe, register select, Din.
  - Outputs: read word, irq.
- tc_multi instantiates NUM_CH copies of tc_channel in a generate loop, decodes the address, muxes Dout and ORs IRQ.

Test Plan:
- Reset then one-shot:
  - Stimulus: ch0 PRESET=5, CTRL=0x9 (EN, IM, mode 00).
  - Response: PEND and IRQ rise 5 edges after LOAD; COUNT=0; EN reads 0; STATUS state returns to IDLE.
- Auto-reload:
  - Stimulus: ch1 PRESET=3, CTRL=0xB.
  - Response: PEND set every 5 cycles, COUNT sequence 3,2,1,0; write 1 to STATUS clears PEND and IRQ drops the same edge.
- Mask and isolation:
  - Stimulus: ch0 CTRL=0x1 (IM=0) counting while a write to ch1 PRESET=7 occurs.
  - Response: ch0 count is not stalled; PEND=1 but IRQ=0; setting IM=1 raises IRQ combinationally.
- Boundaries:
  - PRESET=0 and PRESET=1 both give PEND one edge after LOAD.
  - WIDTH=8 with PRESET write 0x1FF stores 0xFF.
  - Reads of channel index NUM_CH return 0.
- Collision and async reset:
  - W1C on the same cycle COUNT would hit 1: PEND ends 0, then 1 a cycle later.
  - Dropping reset mid-CNT clears all outputs immediately, without waiting for a clk edge.
- TC_PRESCALE_EN:
  - Stimulus: P=2, PRESET=4.
  - Response: PEND 12 cycles after LOAD.
  - Without the macro, a CTRL write of 0x209 reads back 0x9.
